// File: rtl/hmac_sha256_iter.sv
// HMAC-SHA256 engine on a sequential SHA-256 core; with HMAC_ITER_EN defined it
// iterates HMAC and XOR-accumulates the results, producing a PBKDF2 F-block.

module sha256 (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] in,
  input  logic         in_valid,
  input  logic         new_hash,
  output logic         in_ready,
  output logic [255:0] out,
  output logic         out_valid,
  input  logic         out_ready
);
  typedef enum logic [1:0] {C_IDLE, C_RUN, C_OUT} core_state_e;

  localparam logic [0:7][31:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  core_state_e      st_q;
  logic [5:0]       rnd_q;
  logic [0:7][31:0] h_q, v_q, v_nxt;
  logic [0:15][31:0] w_q;
  logic [31:0]      t1, t2, w_new;

  // v_q = {a..h}; w_q[0] is W[t], w_q[15] is W[t+15]
  assign t1 = v_q[7] + (ror(v_q[4], 6) ^ ror(v_q[4], 11) ^ ror(v_q[4], 25))
            + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + K[rnd_q] + w_q[0];
  assign t2 = (ror(v_q[0], 2) ^ ror(v_q[0], 13) ^ ror(v_q[0], 22))
            + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
  assign v_nxt = {t1 + t2, v_q[0], v_q[1], v_q[2], v_q[3] + t1, v_q[4], v_q[5], v_q[6]};
  assign w_new = (ror(w_q[14], 17) ^ ror(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
               + (ror(w_q[1], 7) ^ ror(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];

  assign in_ready  = (st_q == C_IDLE);
  assign out_valid = (st_q == C_OUT);
  assign out       = h_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the schedule and working registers are reset too, so an aborted job leaves no X behind.
      st_q  <= C_IDLE;
      rnd_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
      w_q   <= '0;
    end else begin
      case (st_q)
        C_IDLE: if (in_valid) begin
          w_q   <= in;
          v_q   <= new_hash ? IV : h_q;
          if (new_hash) h_q <= IV;
          rnd_q <= '0;
          st_q  <= C_RUN;
        end
        C_RUN: begin
          v_q   <= v_nxt;
          w_q   <= {w_q[1:15], w_new};
          rnd_q <= rnd_q + 6'd1;
          if (rnd_q == 6'd63) begin
            for (int i = 0; i < 8; i++) h_q[i] <= h_q[i] + v_nxt[i];
            st_q <= C_OUT;
          end
        end
        default: if (out_ready) st_q <= C_IDLE;
      endcase
    end
  end
endmodule

module hmac_sha256_iter #(
  parameter int KEY_W = 256,
  parameter int MSG_W = 256
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [KEY_W-1:0] key_i,
  input  logic [MSG_W-1:0] msg_i,
`ifdef HMAC_ITER_EN
  input  logic [31:0]      iter_i,
`endif
  input  logic             v_i,
  output logic             r_o,
  output logic [255:0]     digest_o,
  output logic             v_o,
  input  logic             r_i
);
  typedef enum logic [2:0] {S_IDLE, S_IKEY, S_IMSG, S_OKEY, S_ODIG, S_DONE} state_e;
  typedef enum logic [1:0] {P_SEND, P_WAIT, P_ACK} phase_e;

  localparam logic [511:0] IPAD    = {64{8'h36}};
  localparam logic [511:0] OPAD    = {64{8'h5c}};
  localparam logic [63:0]  MSG_LEN = 64'(512 + MSG_W);

  // a 256-bit digest following a 64-byte key block, padded as a single block
  function automatic logic [511:0] dig_blk(input logic [255:0] d);
    return {d, 1'b1, 191'b0, 64'd768};
  endfunction

  state_e         state_q;
  phase_e         phase_q;
  logic [511:0]   key_q, core_in_q, key_pad, msg_blk, imsg_blk;
  logic [MSG_W-1:0] msg_q;
  logic [255:0]   inner_q, core_out;
  logic           core_in_valid_q, core_new_hash_q, core_out_ready_q;
  logic           core_in_ready, core_out_valid, core_rst;

  assign key_pad  = 512'(key_i) << (512 - KEY_W);
  assign msg_blk  = {msg_q, 1'b1, {(447 - MSG_W){1'b0}}, MSG_LEN};
  assign core_rst = ~rst_ni;

`ifdef HMAC_ITER_EN
  logic [255:0] acc_q, acc_nxt;
  logic [31:0]  cnt_q, n_q;
  // NOTE: the next accumulator is a continuous assign so the sequential block stays purely non-blocking.
  assign acc_nxt  = acc_q ^ core_out;
  // later iterations hash the previous U, parked in inner_q between iterations
  assign imsg_blk = (cnt_q == 32'd1) ? msg_blk : dig_blk(inner_q);
`else
  assign imsg_blk = msg_blk;
`endif

  sha256 u_core (
    .clk      (clk_i),
    .rst      (core_rst),
    .in       (core_in_q),
    .in_valid (core_in_valid_q),
    .new_hash (core_new_hash_q),
    .in_ready (core_in_ready),
    .out      (core_out),
    .out_valid(core_out_valid),
    .out_ready(core_out_ready_q)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= S_IDLE;
      phase_q          <= P_SEND;
      r_o              <= 1'b0;
      v_o              <= 1'b0;
      digest_o         <= '0;
      key_q            <= '0;
      msg_q            <= '0;
      inner_q          <= '0;
      core_in_q        <= '0;
      core_in_valid_q  <= 1'b0;
      core_new_hash_q  <= 1'b0;
      core_out_ready_q <= 1'b0;
`ifdef HMAC_ITER_EN
      acc_q <= '0;
      cnt_q <= '0;
      n_q   <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (v_i && r_o) begin
          key_q           <= key_pad;
          msg_q           <= msg_i;
          core_in_q       <= key_pad ^ IPAD;
          core_new_hash_q <= 1'b1;
          core_in_valid_q <= 1'b1;
          phase_q         <= P_SEND;
          r_o             <= 1'b0;
          state_q         <= S_IKEY;
`ifdef HMAC_ITER_EN
          acc_q <= '0;
          cnt_q <= 32'd1;
          n_q   <= (iter_i == 32'd0) ? 32'd1 : iter_i;
`endif
        end else begin
          r_o <= 1'b1;
        end
        S_DONE: if (r_i) begin
          v_o     <= 1'b0;
          r_o     <= 1'b1;
          state_q <= S_IDLE;
        end
        default: case (phase_q)
          P_SEND: if (core_in_ready) begin
            core_in_valid_q <= 1'b0;
            phase_q         <= P_WAIT;
          end
          P_WAIT: if (core_out_valid) begin
            core_out_ready_q <= 1'b1;
            phase_q          <= P_ACK;
          end
          default: begin
            core_out_ready_q <= 1'b0;
            core_in_valid_q  <= 1'b1;
            core_new_hash_q  <= 1'b0;
            phase_q          <= P_SEND;
            case (state_q)
              S_IKEY: begin
                core_in_q <= imsg_blk;
                state_q   <= S_IMSG;
              end
              S_IMSG: begin
                inner_q         <= core_out;
                core_in_q       <= key_q ^ OPAD;
                core_new_hash_q <= 1'b1;
                state_q         <= S_OKEY;
              end
              S_OKEY: begin
                core_in_q <= dig_blk(inner_q);
                state_q   <= S_ODIG;
              end
              default: begin
`ifdef HMAC_ITER_EN
                acc_q <= acc_nxt;
                if (cnt_q == n_q) begin
                  core_in_valid_q <= 1'b0;
                  digest_o        <= acc_nxt;
                  v_o             <= 1'b1;
                  state_q         <= S_DONE;
                end else begin
                  inner_q         <= core_out;
                  cnt_q           <= cnt_q + 32'd1;
                  core_in_q       <= key_q ^ IPAD;
                  core_new_hash_q <= 1'b1;
                  state_q         <= S_IKEY;
                end
`else
                core_in_valid_q <= 1'b0;
                digest_o        <= core_out;
                v_o             <= 1'b1;
                state_q         <= S_DONE;
`endif
              end
            endcase
          end
        endcase
      endcase
    end
  end
endmodule

// File: tb/tb_hmac_sha256_iter.sv
// Scoreboard bench for hmac_sha256_iter: two instances (32/224 and 64/64 widths) checked against known HMAC/PBKDF2 vectors.
module tb_hmac_sha256_iter;
  localparam logic [255:0] JEFE      = 256'h5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843;
  localparam logic [255:0] PASSWD_1  = 256'h55ac046e56e3089fec1691c22544b605f94185216dde0465e68b9d57c20dacbc;
  localparam logic [255:0] PASSWORD_1 = 256'h120fb6cffcf8b32c43e7225256c4f837a86548c92ccc35480805987cb70be17b;
  localparam logic [31:0]  KEY_JEFE  = 32'h4a656665;
  localparam logic [223:0] MSG_JEFE  = "what do ya want for nothing?";
  localparam logic [63:0]  KEY_PASSWD = {"passwd", 16'h0000};
  localparam logic [63:0]  KEY_PASSWORD = "password";
  localparam logic [63:0]  SALT_1    = 64'h73616c7400000001;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [31:0]  key_a;
  logic [223:0] msg_a;
  logic         v_a, r_a, vo_a, ri_a;
  logic [255:0] dig_a;
  logic [63:0]  key_b, msg_b;
  logic         v_b, r_b, vo_b, ri_b;
  logic [255:0] dig_b;
`ifdef HMAC_ITER_EN
  logic [31:0]  iter_b;
`endif

  hmac_sha256_iter #(.KEY_W(32), .MSG_W(224)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .key_i(key_a), .msg_i(msg_a),
`ifdef HMAC_ITER_EN
    .iter_i(32'd1),
`endif
    .v_i(v_a), .r_o(r_a), .digest_o(dig_a), .v_o(vo_a), .r_i(ri_a));

  hmac_sha256_iter #(.KEY_W(64), .MSG_W(64)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .key_i(key_b), .msg_i(msg_b),
`ifdef HMAC_ITER_EN
    .iter_i(iter_b),
`endif
    .v_i(v_b), .r_o(r_b), .digest_o(dig_b), .v_o(vo_b), .r_i(ri_b));

  int vectors = 0;
  int miscompares = 0;
  logic [255:0] exp_a[$];
  logic [255:0] exp_b[$];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // completed results are popped on the output handshake
  always @(negedge clk) begin
    if (rst_n && vo_a && ri_a) begin
      if (exp_a.size() == 0) check("a_unexpected_output", 1'b1, 1'b0);
      else check("a_digest", dig_a, exp_a.pop_front());
    end
    if (rst_n && vo_b && ri_b) begin
      if (exp_b.size() == 0) check("b_unexpected_output", 1'b1, 1'b0);
      else check("b_digest", dig_b, exp_b.pop_front());
    end
  end

  task automatic send_a(input logic [31:0] k, input logic [223:0] m);
    int n = 0;
    key_a = k; msg_a = m; v_a = 1'b1;
    while (!r_a && n < 3000) begin @(posedge clk); #1; n++; end
    check("a_accept", r_a, 1'b1);
    @(posedge clk); #1;
    v_a = 1'b0;
  endtask

  task automatic send_b(input logic [63:0] k, input logic [63:0] m);
    int n = 0;
    key_b = k; msg_b = m; v_b = 1'b1;
    while (!r_b && n < 3000) begin @(posedge clk); #1; n++; end
    check("b_accept", r_b, 1'b1);
    @(posedge clk); #1;
    v_b = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_a.size() != 0 || exp_b.size() != 0) && n < budget) begin @(posedge clk); #1; n++; end
    check("drain_in_time", n < budget, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; v_a = 1'b0; v_b = 1'b0; ri_a = 1'b1; ri_b = 1'b1;
    key_a = '0; msg_a = '0; key_b = '0; msg_b = '0;
`ifdef HMAC_ITER_EN
    iter_b = 32'd1;
`endif
    #1;
    check("rst_r_a", r_a, 1'b0);
    check("rst_v_a", vo_a, 1'b0);
    check("rst_dig_a", dig_a, '0);
    check("rst_r_b", r_b, 1'b0);
    check("rst_v_b", vo_b, 1'b0);
    check("rst_dig_b", dig_b, '0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_r_a", r_a, 1'b1);
    check("post_rst_r_b", r_b, 1'b1);

    // plain HMAC vectors on both widths, run concurrently
    exp_a.push_back(JEFE);
    send_a(KEY_JEFE, MSG_JEFE);
    exp_b.push_back(PASSWD_1);
    send_b(KEY_PASSWD, SALT_1);
    drain(3000);
    exp_b.push_back(PASSWORD_1);
    send_b(KEY_PASSWORD, SALT_1);
    drain(3000);

`ifdef HMAC_ITER_EN
    // zero iterations behaves as one; two iterations XOR-accumulates U1 ^ U2
    iter_b = 32'd0;
    exp_b.push_back(PASSWD_1);
    send_b(KEY_PASSWD, SALT_1);
    drain(3000);
    iter_b = 32'd2;
    exp_b.push_back(256'hae4d0c95af6b46d32d0adff928f06dd02a303f8ef3c251dfd6e2d85a95474c43);
    send_b(KEY_PASSWORD, SALT_1);
    drain(3000);
    iter_b = 32'd1;
`endif

    // back-pressure: result held for 20 cycles with v_i high, no new job accepted
    ri_a = 1'b0;
    exp_a.push_back(JEFE);
    key_a = KEY_JEFE; msg_a = MSG_JEFE; v_a = 1'b1;
    n = 0;
    while (!r_a && n < 3000) begin @(posedge clk); #1; n++; end
    check("a_bp_accept", r_a, 1'b1);
    @(posedge clk); #1;
    n = 0;
    while (!vo_a && n < 3000) begin @(posedge clk); #1; n++; end
    check("a_bp_done", vo_a, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("a_bp_v_held", vo_a, 1'b1);
      check("a_bp_dig_held", dig_a, JEFE);
      check("a_bp_r_low", r_a, 1'b0);
    end
    exp_a.push_back(JEFE);
    ri_a = 1'b1;
    @(posedge clk); #1;
    check("a_bp_release_v", vo_a, 1'b0);
    check("a_bp_release_r", r_a, 1'b1);
    @(posedge clk); #1;
    v_a = 1'b0;
    check("a_bp_second_started", r_a, 1'b0);
    drain(3000);

    // reset in the middle of the outer-digest hash aborts the job silently
    send_a(KEY_JEFE, MSG_JEFE);
    repeat (229) @(posedge clk);
    #1;
    check("a_abort_no_output_yet", vo_a, 1'b0);
    rst_n = 1'b0;
    #1;
    check("a_abort_v", vo_a, 1'b0);
    check("a_abort_dig", dig_a, '0);
    check("a_abort_r", r_a, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_a.push_back(JEFE);
    send_a(KEY_JEFE, MSG_JEFE);
    drain(3000);

    check("scoreboard_empty", 256'(exp_a.size() + exp_b.size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hmac_sha256_iter.md
HMAC_SHA256_ITER -- requirements
Module: hmac_sha256_iter

Interface
REQ-001 KEY_W, default 256, key width in bits; multiple of 8, range 8..512; key is zero-padded on the right to 512 bits.
REQ-002 MSG_W, default 256, first-message width in bits; multiple of 8, range 8..447, so message plus padding fits one block.
REQ-003 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_ni  input  1  asynchronous, active-low reset.
REQ-005 key_i  input  KEY_W  HMAC key, big-endian byte order, captured on input handshake.
REQ-006 msg_i  input  MSG_W  first message, e.g. salt||INT(i), captured on input handshake.
REQ-007 iter_i  input  32  iteration count, present only when HMAC_ITER_EN is defined.
REQ-008 v_i  input  1  input valid.
REQ-009 r_o  output  1  input ready.
REQ-010 digest_o  output  256  result: HMAC digest, or PBKDF2 F-block when iterating.
REQ-011 v_o  output  1  result valid.
REQ-012 r_i  input  1  downstream ready.

Function
REQ-013 The block shall instantiate the existing sha256 core.
- Core reset driven by ~rst_ni.
- Core in, in_valid and new_hash driven from registers.
REQ-014 Input handshake:
- r_o shall be 1 only in IDLE.
- key, message and iteration count are captured when v_i && r_o.
REQ-015 Output handshake:
- v_o shall be 1 only in DONE.
- digest_o is registered and held stable until v_o && r_i.
- The block then returns to IDLE on the next cycle.
REQ-016 FSM states: IDLE -> IKEY -> IMSG -> OKEY -> ODIG -> (ACC) -> DONE.
- Each hash state first holds in_valid=1 with its block until core in_ready=1.
- It then waits for core out_valid=1.
- It then pulses core out_ready for exactly one cycle while capturing out.
REQ-017 IKEY block = {K ^ {64{8'h36}}}, new_hash=1; OKEY block = {K ^ {64{8'h5c}}}, new_hash=1.
REQ-018 IMSG block, new_hash=0: {M, 1'b1, zeros, 64-bit length L}.
- Iteration 1: M=msg_i, L=512+MSG_W.
- Later iterations: M=previous U, L=768.
REQ-019 ODIG block = {inner digest, 1'b1, 191'b0, 64'd768}, new_hash=0.
REQ-020 Per iteration, the resulting U shall be XOR-accumulated into an accumulator cleared on input handshake; digest_o shall take the accumulator value.
REQ-021 Iteration counter:
- Counts from 1 to N.
- After the ODIG of iteration k<N, the FSM returns to IKEY with U_k as the message.
- When k==N, the FSM goes to DONE.
REQ-022 N=0 shall be treated as N=1.
REQ-023 No overlap: a new input is not accepted while a job is in flight or DONE is pending.

Reset
REQ-024 On rst_ni low, asynchronously:
- FSM to IDLE.
- r_o=0 while reset is asserted, 1 after release.
- v_o=0, digest_o=0, accumulator and counter 0, core in_valid/out_ready 0.
REQ-025 Reset asserted mid-hash shall abort the job with no output produced; the first handshake after release starts a fresh job.

Configuration
REQ-026 HMAC_ITER_EN defined: iter_i is present and REQ-020..REQ-022 apply.
REQ-027 HMAC_ITER_EN undefined:
- iter_i is absent.
- N is fixed at 1, so the result is a plain HMAC.
- No accumulator or counter is synthesised.

Verification
REQ-028 KEY_W=32, MSG_W=224, key=4a656665, msg="what do ya want for nothing?" -> digest_o=5bdcc146bf60754e6a042426089575c75a003f089d2739839dec58b964ec3843.
REQ-029 KEY_W=48, MSG_W=64, key="passwd", msg=73616c7400000001, iter=1 -> 55ac046e56e3089fec1691c22544b605f94185216dde0465e68b9d57c20dacbc.
REQ-030 HMAC_ITER_EN, KEY_W=64, MSG_W=64, key="password", msg=73616c7400000001, iter=4096 -> c5e478d59288c841aa530db6845c4c8d962893a001ce4e11a4963873aa98134a.
REQ-031 Test vector of REQ-029 with iter=0 -> same digest as iter=1.
REQ-032 Back-pressure check:
- Stimulus: r_i=0 for 20 cycles in DONE, v_i=1 throughout.
- Response: digest_o and v_o stable, r_o=0; the next job starts only after the r_i handshake.
REQ-033 rst_ni pulsed low during ODIG -> v_o=0 and digest_o=0 immediately; the next job on REQ-028 inputs produces the correct digest.
